fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core. It owns the program counter, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs. It delivers them through a valid/ready interface to the decode stage, which derives ImmSrc/isLUI and feeds the immediate generator. Taken branches and jumps are signalled back by execute as a redirect; the redirect flushes the buffer and drops any responses still in flight.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Core-wide definitions shared by the pipeline stages: widths, reset vector, fetch FSM states.
// No logic of its own; word_align drops the byte offset of a fetch address.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    WAIT,
    FETCH,
    FLUSH
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; the head is read straight from storage, a push shows one edge later.
// A push into a full FIFO without a same-cycle pop is dropped and trips an assertion; flush wins over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_dat,
  output logic [WIDTH-1:0]           o_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop   = i_pop && (r_count != '0);
  assign w_push  = i_push && ((r_count != CW'(DEPTH)) || w_pop);
  assign o_dat   = r_mem[r_rd];
  assign o_count = r_count;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      assert (!(i_push && !w_push));
      if (w_push) begin
        r_mem[r_wr] <= i_dat;
        r_wr        <= nxt(r_wr);
      end
      if (w_pop) r_rd <= nxt(r_rd);
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, requests words from imem and buffers {pc, instr} for decode; grant in N gives instr_valid in N+2.
// Requests stop once in-flight plus buffered instructions reach DEPTH; a redirect flushes and discards stale responses.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = CW + 1;

  fetch_state_t r_state;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   w_occ;
  logic [CW-1:0]   w_pcq_cnt;
  logic [CW-1:0]   w_discard_redir;
  logic [LW-1:0]   w_level;
  logic [XLEN-1:0] w_pcq_head;
  logic [XLEN+ILEN-1:0] w_buf_dat;
  logic            w_pop;
  logic            w_gnt;
  logic            w_keep;

  assign w_pop       = instr_valid && instr_ready;
  assign w_level     = LW'(r_outst) + LW'(w_occ) - LW'(w_pop);
  assign imem_req    = (r_state == FETCH) && !redirect && (w_level < LW'(DEPTH));
  assign imem_addr   = r_pc;
  assign w_gnt       = imem_req && imem_gnt;
  assign w_keep      = imem_rvalid && (r_discard == '0);
  assign instr_valid = (w_occ != '0);
  assign {instr_pc, instr} = w_buf_dat;

  // Every granted request still lacking a response becomes a response to throw away.
  assign w_discard_redir = r_outst - CW'(w_keep)
                         + ((r_discard != '0) ? r_discard - CW'(imem_rvalid) : '0);

  fetch_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(DEPTH)) u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_keep),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_dat   ({w_pcq_head, imem_rdata}),
    .o_dat   (w_buf_dat),
    .o_count (w_occ)
  );

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pcq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_gnt),
    .i_pop   (w_keep),
    .i_flush (redirect),
    .i_dat   (r_pc),
    .o_dat   (w_pcq_head),
    .o_count (w_pcq_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= WAIT;
      r_pc      <= RESET_PC;
      r_outst   <= '0;
      r_discard <= '0;
    end else if (redirect) begin
      r_pc      <= word_align(redirect_pc);
      r_outst   <= '0;
      r_discard <= w_discard_redir;
      r_state   <= (w_discard_redir != '0) ? FLUSH : FETCH;
    end else begin
      assert (w_pcq_cnt == r_outst);
      if (w_gnt) r_pc <= r_pc + XLEN'(4);
      if (w_gnt && !w_keep) r_outst <= r_outst + 1'b1;
      else if (!w_gnt && w_keep) r_outst <= r_outst - 1'b1;
      if (imem_rvalid && (r_discard != '0)) r_discard <= r_discard - 1'b1;
      case (r_state)
        WAIT:    r_state <= FETCH;
        FLUSH:   if (r_discard == CW'(imem_rvalid)) r_state <= FETCH;
        default: r_state <= r_state;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a stream-level model of the fetch contract.
// Memory model grants/responds in order with random latency; the model tracks expected PCs and stale responses.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t mq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_pct = 100, rdy_pct = 100, redir_pct = 0, dmin = 1, dmax = 1;
  bit f_redir = 0;
  logic [31:0] f_rpc = '0;
  logic [31:0] exp_pc, exp_req, hold_addr, p_instr, p_pc, last_pop_pc;
  int live, stale, grants, pops, pops0, first_gnt, first_vld, first_req, redir_cyc, rel_cyc;
  bit hold_pend, p_hold, prev_redir, exp_req_next, s_simul;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    bit pop, was_stale;
    @(negedge clk);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memw(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    instr_ready = ($urandom_range(99) < rdy_pct);
    if (f_redir) begin
      redirect = 1'b1; redirect_pc = f_rpc; f_redir = 0;
    end else if ($urandom_range(99) < redir_pct) begin
      redirect = 1'b1; redirect_pc = $urandom;
    end else begin
      redirect = 1'b0;
    end
    #1;
    pop = instr_valid && instr_ready;
    if (prev_redir) chk("vld_after_redir", 32'(instr_valid), 0);
    if (p_hold) begin
      chk("hold_vld", 32'(instr_valid), 1);
      chk("hold_instr", instr, p_instr);
      chk("hold_pc", instr_pc, p_pc);
    end
    if (exp_req_next) chk("req_resume", 32'(imem_req), 32'(!redirect));
    if (stale > 0) chk("req_in_flush", 32'(imem_req), 0);
    if (hold_pend && !redirect) begin
      chk("req_hold", 32'(imem_req), 1);
      chk("addr_hold", imem_addr, hold_addr);
    end
    if (imem_req) begin
      chk("req_addr", imem_addr, exp_req);
      if (first_req < 0) first_req = cyc;
    end
    chk("req_limit", 32'(imem_req && ((live - int'(pop)) >= DEPTH)), 0);
    if (instr_valid && first_vld < 0) first_vld = cyc;
    if (pop && !redirect) begin
      chk("pop_pc", instr_pc, exp_pc);
      chk("pop_instr", instr, memw(exp_pc));
      last_pop_pc = instr_pc;
      exp_pc += 32'd4;
      live--;
      pops++;
    end
    if (imem_req && imem_gnt) begin
      mq.push_back('{imem_addr, cyc + int'($urandom_range(dmax, dmin))});
      exp_req += 32'd4;
      live++;
      grants++;
      if (first_gnt < 0) first_gnt = cyc;
    end
    was_stale = (stale > 0);
    if (imem_rvalid) begin
      mq.delete(0);
      if (stale > 0) stale--;
    end
    exp_req_next = 0;
    if (redirect) begin
      exp_pc       = {redirect_pc[31:2], 2'b00};
      exp_req      = exp_pc;
      live         = 0;
      stale        = mq.size();
      exp_req_next = (stale == 0);
      redir_cyc    = cyc;
    end else if (was_stale && stale == 0) begin
      exp_req_next = 1;
    end
    hold_pend  = imem_req && !imem_gnt;
    hold_addr  = imem_addr;
    p_hold     = instr_valid && !instr_ready && !redirect;
    p_instr    = instr;
    p_pc       = instr_pc;
    prev_redir = redirect;
    s_simul    = redirect && imem_rvalid && pop;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_vld", 32'(instr_valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_addr", imem_addr, RPC);
    mq.delete();
    live = 0; stale = 0; grants = 0; pops = 0;
    exp_pc = RPC; exp_req = RPC;
    hold_pend = 0; p_hold = 0; prev_redir = 0;
    first_gnt = -1; first_vld = -1; first_req = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("wait_idle", 32'(imem_req), 0);
    rel_cyc = cyc;
    exp_req_next = 1;
    cyc++;
  endtask

  initial begin
    // Reset, first fetch latency and zero-wait streaming.
    do_reset();
    for (int i = 0; i < 20 && first_vld < 0; i++) step();
    chk("first_req_cyc", 32'(first_req - rel_cyc), 1);
    chk("first_latency", 32'(first_vld - first_gnt), 2);
    chk("first_pc", last_pop_pc, RPC);
    repeat (9) step();
    chk("stream_pops", 32'(pops), 10);
    chk("stream_last_pc", last_pop_pc, 32'h24);

    // Backpressure: decode stalled, then released.
    rdy_pct = 0;
    do_reset();
    repeat (8) step();
    chk("bp_grants", 32'(grants), DEPTH);
    chk("bp_req_low", 32'(imem_req), 0);
    chk("bp_head_pc", instr_pc, RPC);
    rdy_pct = 100;
    repeat (6) step();
    chk("bp_drain", 32'(pops >= 4), 1);

    // Redirect with two requests still in flight.
    dmin = 3; dmax = 3;
    do_reset();
    for (int i = 0; i < 10 && grants < 2; i++) step();
    f_redir = 1; f_rpc = 32'h0000_0103;
    step();
    chk("rd_stale", 32'(stale), 2);
    first_req = -1; pops0 = pops;
    for (int i = 0; i < 30 && pops == pops0; i++) step();
    chk("rd_first_pc", last_pop_pc, 32'h0000_0100);
    chk("rd_req_latency", 32'(first_req - redir_cyc), 3);

    // Redirect, response and pop in the same cycle; then a wrap past the top of memory.
    dmin = 1; dmax = 1;
    do_reset();
    for (int i = 0; i < 20 && pops < 3; i++) step();
    f_redir = 1; f_rpc = 32'h0000_2000;
    step();
    chk("sim_events", 32'(s_simul), 1);
    pops0 = pops;
    for (int i = 0; i < 20 && pops == pops0; i++) step();
    chk("sim_first_pc", last_pop_pc, 32'h0000_2000);
    f_redir = 1; f_rpc = 32'hFFFF_FFFA;
    step();
    pops0 = pops;
    for (int i = 0; i < 30 && (pops - pops0) < 4; i++) step();
    chk("wrap_pc", last_pop_pc, 32'h0000_0004);

    // Asynchronous reset in the middle of a stream.
    do_reset();
    for (int i = 0; i < 20 && pops == 0; i++) step();
    chk("restart_pc", last_pop_pc, RPC);

    // Randomized traffic with random redirects.
    for (int r = 0; r < 6; r++) begin
      gnt_pct   = $urandom_range(100, 30);
      rdy_pct   = $urandom_range(100, 20);
      dmin      = $urandom_range(3, 1);
      dmax      = dmin + $urandom_range(3, 0);
      redir_pct = $urandom_range(6, 1);
      do_reset();
      repeat (400) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
